// File: rtl/input_ctrl_pkg.sv
// Shared definitions for the CPU input controller.
//   state_t      : controller FSM states
//   BTN_CONFIRM  : index of the confirm button within btn
//   BTN_CANCEL   : index of the cancel button within btn
package input_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    DELIVER = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int unsigned BTN_CONFIRM = 0;
  localparam int unsigned BTN_CANCEL  = 1;

endpackage

// File: rtl/input_ctrl_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter, press strobe.
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw        : raw button input, asynchronous to clk
//   level      : debounced button level
//   press      : one-cycle strobe, registered together with a 0->1 change of level
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles in which the synchronized level disagrees
  // with level; it stops at LAST (flip point) so it can never wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] != level) begin
        if (cnt == LAST) begin
          level <= sync[1];
          press <= sync[1];
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/input_ctrl.sv
// CPU input controller: delivers the slide-switch value as one input word
// when the CPU requests input and the operator confirms with a button press.
//   clk, rst_n : system clock, asynchronous active-low reset
//   sw         : raw slide switches (asynchronous)
//   btn        : raw buttons, [0] confirm, [1] cancel, [2] ignored
//   in_req     : CPU level request, held while IN executes
//   in_valid   : one-cycle strobe, in_data valid
//   in_data    : captured switch value, zero-extended
//   busy       : controller not idle
module input_ctrl
  import input_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 16,
  parameter int unsigned SW_WIDTH        = 9,
  parameter int unsigned DEBOUNCE_CYCLES = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SW_WIDTH-1:0]   sw,
  input  logic [2:0]            btn,
  input  logic                  in_req,
  output logic                  in_valid,
  output logic [DATA_WIDTH-1:0] in_data,
  output logic                  busy
);

  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic                confirm_level;
  logic                confirm_press;
  logic                cancel_level;
  logic                cancel_press;
  logic                unused_bits;
  state_t              state;
  state_t              state_next;

  assign unused_bits = ^{btn[2], cancel_level};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw;
      sw_sync <= sw_meta;
    end
  end

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_confirm (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn[BTN_CONFIRM]),
    .level (confirm_level),
    .press (confirm_press)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cancel (
    .clk   (clk),
    .rst_n (rst_n),
    .raw   (btn[BTN_CANCEL]),
    .level (cancel_level),
    .press (cancel_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Cancel is tested before confirm so a simultaneous pair aborts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_req) state_next = ARMED;
      end
      ARMED: begin
        if (cancel_press || !in_req) state_next = IDLE;
        else if (confirm_press)      state_next = DELIVER;
      end
      DELIVER: begin
        state_next = RELEASE;
      end
      RELEASE: begin
        if (!confirm_level && !in_req) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // DELIVER always lasts one cycle, so entering it is simply state_next == DELIVER.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_data <= '0;
    end else if (state_next == DELIVER) begin
      in_data <= DATA_WIDTH'(sw_sync);
    end
  end

  assign in_valid = (state == DELIVER);
  assign busy     = (state != IDLE);

endmodule

// File: doc/input_ctrl.md
INPUT_CTRL -- requirements
Module: input_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of the CPU input word.
REQ-002 Parameter SW_WIDTH, default 9, number of slide switches.
REQ-003 Parameter DEBOUNCE_CYCLES, default 5, clk cycles a synchronized button level must stay stable before it is accepted.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 sw  input  SW_WIDTH  raw slide switches, asynchronous to clk.
REQ-007 btn  input  3  raw push buttons: btn[0] confirm, btn[1] cancel, btn[2] unused (ignored); asynchronous to clk.
REQ-008 in_req  input  1  CPU level request for an input word; held high while the CPU executes IN.
REQ-009 in_valid  output  1  one-cycle strobe: in_data is valid.
REQ-010 in_data  output  DATA_WIDTH  switch value zero-extended to DATA_WIDTH.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 Each btn bit and each sw bit SHALL pass through a 2-flop synchronizer before use.
REQ-013 A button's debounced level SHALL change only after its synchronized level has differed from the current debounced level for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
REQ-014 A press event SHALL be one cycle, issued on the debounced 0->1 transition only.
REQ-015 FSM states: IDLE, ARMED, DELIVER, RELEASE.
REQ-016 IDLE -> ARMED when in_req=1; press events while in IDLE SHALL be discarded.
REQ-017 ARMED -> DELIVER on a confirm press event while in_req=1; ARMED -> IDLE on a cancel press event or when in_req=0.
REQ-018 On entry to DELIVER, in_data SHALL capture the synchronized sw, zero-extended; in_valid=1 for exactly the one cycle spent in DELIVER.
REQ-019 DELIVER -> RELEASE unconditionally after one cycle.
REQ-020 RELEASE -> IDLE once debounced confirm=0 and in_req=0; no new delivery before both hold.
REQ-021 A confirm and a cancel press event in the same cycle in ARMED: cancel SHALL win (-> IDLE, no in_valid).
REQ-022 in_data SHALL hold its last captured value outside DELIVER.
REQ-023 Latency: in_valid SHALL rise exactly 1 cycle after the cycle carrying the confirm press event in ARMED.
REQ-024 The debounce counter SHALL be sized ceil(log2(DEBOUNCE_CYCLES+1)) bits and SHALL never wrap.

Reset
REQ-025 rst_n=0 SHALL immediately force: state IDLE, in_valid=0, in_data=0, busy=0, synchronizers=0, debounced levels=0, counters=0.
REQ-026 Reset asserted mid-delivery SHALL abort it with no in_valid pulse; after release the block SHALL be in IDLE.
REQ-027 A button already held when reset deasserts SHALL produce one press event after DEBOUNCE_CYCLES+2 cycles, discarded if the FSM is in IDLE.

Structure
REQ-028 Shared package input_ctrl_pkg SHALL hold the FSM state enum and button index constants (BTN_CONFIRM=0, BTN_CANCEL=1).
REQ-029 One sub-module, debounce (synchronizer + stability counter + press-event output, parameter DEBOUNCE_CYCLES), SHALL be instantiated per used button.

Verification (DEBOUNCE_CYCLES=4, DATA_WIDTH=16)
REQ-030 sw=9'h008, in_req=1, clean btn[0] press -> one in_valid pulse, in_data=16'h0008, 1 cycle after the press event.
REQ-031 btn[0] bounces 1-0-1-0-1 at 2-cycle intervals then holds high, sw=9'h009 -> exactly one in_valid, in_data=16'h0009.
REQ-032 in_req=1, btn[0] and btn[1] press events in the same cycle -> no in_valid, state IDLE, busy=0.
REQ-033 btn[0] held through delivery and in_req kept high -> no second in_valid until btn[0] released and in_req dropped; next request + press with sw=9'h003 -> in_data=16'h0003.
REQ-034 Press btn[0] with in_req=0, then raise in_req -> no in_valid until a fresh press.
REQ-035 rst_n pulsed low in the cycle the press event is generated -> in_valid stays 0, in_data=0, busy=0.
